// File: rtl/legv8_pkg.sv
// ----------------------------------------------------------------------------
// legv8_pkg
// Shared definitions for the LEGv8 front end. It holds the following:
//   - Data and address widths (INSTR_W, ADDR_W).
//   - Opcode constants used to decode branch formats and memory operations.
//   - The fetch state encoding used by instruction_fetch_unit.
//   - A helper function that classifies a B-type (unconditional branch) opcode.
// ----------------------------------------------------------------------------
package legv8_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 64;

    // Opcode fields, MSB-aligned to instr[31:21]
    localparam logic [5:0]  OP_B_PREFIX = 6'b000101;
    localparam logic [7:0]  OP_CBZ      = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ     = 8'b10110101;
    localparam logic [10:0] OP_LDUR     = 11'h7C2;
    localparam logic [10:0] OP_STUR     = 11'h7C0;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

    // B-type is identified by the top six opcode bits alone.
    function automatic logic is_b_type(input logic [10:0] op);
        return op[10:5] == OP_B_PREFIX;
    endfunction

endpackage

// File: rtl/branch_target_gen.sv
// ----------------------------------------------------------------------------
// branch_target_gen
// This is a combinational PC-relative branch target generator.
// It selects the offset from the instruction and sign-extends it to 64 bits.
// It then scales the offset by 4 and adds it to pc, modulo 2^64.
//   - B-type:  offset = instr[25:0]  (imm26)
//   - CB-type: offset = instr[23:5]  (imm19, CBZ/CBNZ)
// Ports:
//   pc     in  64  address of the branch instruction
//   instr  in  32  the branch instruction word
//   target out 64  pc + (sext(offset) << 2)
// ----------------------------------------------------------------------------
module branch_target_gen
    import legv8_pkg::*;
(
    input  logic [ADDR_W-1:0]  pc,
    input  logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  target
);

    logic [ADDR_W-1:0] b_offset;
    logic [ADDR_W-1:0] cb_offset;

    // The sign extension and the <<2 are folded into one concatenation.
    // 36 + 26 + 2 = 64 and 43 + 19 + 2 = 64.
    assign b_offset  = {{36{instr[25]}}, instr[25:0], 2'b00};
    assign cb_offset = {{43{instr[23]}}, instr[23:5], 2'b00};

    // The addition wraps silently past 2^64-1.
    assign target = pc + (is_b_type(instr[31:21]) ? b_offset : cb_offset);

endmodule

// File: rtl/instruction_fetch_unit.sv
// ----------------------------------------------------------------------------
// instruction_fetch_unit
// This unit owns the LEGv8 program counter.
// It fetches one 32-bit word at a time over a req/ack handshake.
// It holds each word for the consumer under a valid/ready handshake.
// When the consumer accepts a word, the PC advances. It goes either to pc+4 or
// to the PC-relative branch target, as selected by take_branch.
//
// Optional feature, enabled by the macro IFU_HALT_ON_ZERO_EN:
//   A captured all-zero word parks the unit in HALT.
//   Only reset leaves HALT.
//   When the macro is undefined, halted is tied low and 32'h0 is an ordinary word.
//
// Ports:
//   clk          in   1   clock
//   rst_n        in   1   synchronous active-low reset
//   imem_req     out  1   fetch request (FETCH state, forced low during reset)
//   imem_addr    out  64  byte address of requested word (= pc)
//   imem_ack     in   1   memory data valid this cycle
//   imem_rdata   in   32  instruction word
//   instr        out  32  held instruction word
//   opcode       out  11  instr[31:21]
//   pc_out       out  64  address of the held instruction
//   instr_valid  out  1   instr/opcode/pc_out are valid
//   instr_ready  in   1   consumer accepts this cycle
//   take_branch  in   1   branch taken for the accepted instruction
//   halted       out  1   unit is parked in HALT
// ----------------------------------------------------------------------------
module instruction_fetch_unit
    import legv8_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 64'h0
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic                imem_ack,
    input  logic [INSTR_W-1:0]  imem_rdata,
    output logic [INSTR_W-1:0]  instr,
    output logic [10:0]         opcode,
    output logic [ADDR_W-1:0]   pc_out,
    output logic                instr_valid,
    input  logic                instr_ready,
    input  logic                take_branch,
    output logic                halted
);

    fetch_state_t       state_reg;
    logic [ADDR_W-1:0]  pc_reg;
    logic [INSTR_W-1:0] instr_reg;
    logic [ADDR_W-1:0]  branch_target;
    logic [ADDR_W-1:0]  pc_next;

    branch_target_gen u_branch_target_gen (
        .pc     (pc_reg),
        .instr  (instr_reg),
        .target (branch_target)
    );

    assign pc_next = take_branch ? branch_target : (pc_reg + 64'd4);

    // The single-request protocol keeps the FSM simple.
    // The address is just pc_reg, which stays stable until ack.
    // An ack outside FETCH is ignored because only the FETCH arm looks at it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= FETCH;
            pc_reg    <= RESET_PC;
            instr_reg <= '0;
        end else begin
            case (state_reg)
                FETCH: begin
                    if (imem_ack) begin
                        instr_reg <= imem_rdata;
`ifdef IFU_HALT_ON_ZERO_EN
                        state_reg <= (imem_rdata == '0) ? HALT : HOLD;
`else
                        state_reg <= HOLD;
`endif
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        pc_reg    <= pc_next;
                        state_reg <= FETCH;
                    end
                end
                default: begin
                    // HALT is sticky. Only reset leaves it.
                    state_reg <= state_reg;
                end
            endcase
        end
    end

    // The outputs are decoded from registered state.
    // The request is also gated by rst_n, so it is low during the reset cycle.
    // An in-flight fetch is therefore dropped immediately.
    assign imem_req    = rst_n && (state_reg == FETCH);
    assign imem_addr   = pc_reg;
    assign instr       = instr_reg;
    assign opcode      = instr_reg[31:21];
    assign pc_out      = pc_reg;
    assign instr_valid = (state_reg == HOLD);

`ifdef IFU_HALT_ON_ZERO_EN
    assign halted = (state_reg == HALT);
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed testbench for instruction_fetch_unit.
// Inputs are driven 1 time unit after each rising edge.
// Outputs are sampled at the same point, away from the edge.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [10:0] opcode;
    logic [63:0] pc_out;
    logic        instr_valid;
    logic        instr_ready;
    logic        take_branch;
    logic        halted;

    int n_checks = 0;
    int n_fails  = 0;

    localparam logic [31:0] W_ADD   = 32'h8B020020;
    localparam logic [31:0] W_CBZ   = 32'hB4000040;  // imm19 = 2
    localparam logic [31:0] W_B_M1  = 32'h17FFFFFF;  // imm26 = -1
    localparam logic [31:0] W_B_3D  = 32'h1400003D;  // imm26 = 0x3D -> +0xF4

    instruction_fetch_unit #(.RESET_PC(64'h0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .opcode      (opcode),
        .pc_out      (pc_out),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .take_branch (take_branch),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want $finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Return one word with a single-cycle ack. The unit must be in FETCH.
    task automatic do_fetch(input logic [31:0] word);
        $display("fetch addr=%h word=%h", imem_addr, word);
        imem_ack   = 1'b1;
        imem_rdata = word;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEADBEEF;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        imem_ack    = 1'b0;
        instr_ready = 1'b0;
        take_branch = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        imem_ack    = 1'b1;          // ignored during reset
        imem_rdata  = W_ADD;
        instr_ready = 1'b0;
        take_branch = 1'b0;
        tick();
        tick();
        imem_ack = 1'b0;
        n_checks++; if (imem_req !== 1'b0) begin n_fails++; $display("FAIL reset_req: got %b want 0", imem_req); end
        n_checks++; if (imem_addr !== 64'h0) begin n_fails++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
        n_checks++; if (instr_valid !== 1'b0) begin n_fails++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        n_checks++; if (instr !== 32'h0) begin n_fails++; $display("FAIL reset_instr: got %h want 0", instr); end
        n_checks++; if (halted !== 1'b0) begin n_fails++; $display("FAIL reset_halted: got %b want 0", halted); end
        rst_n = 1'b1;
        #1;
        n_checks++; if (imem_req !== 1'b1) begin n_fails++; $display("FAIL post_reset_req: got %b want 1", imem_req); end
        $display("reset done");
    endtask

    task automatic test_zero_wait();
        logic [63:0] exp_addr;
        exp_addr    = 64'h0;
        instr_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (imem_req !== 1'b1 || imem_addr !== exp_addr) begin
                n_fails++; $display("FAIL zw_fetch%0d: got req=%b addr=%h want req=1 addr=%h", k, imem_req, imem_addr, exp_addr); end
            n_checks++; if (instr_valid !== 1'b0) begin n_fails++; $display("FAIL zw_valid_lo%0d: got %b want 0", k, instr_valid); end
            do_fetch(W_ADD);
            n_checks++; if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin
                n_fails++; $display("FAIL zw_hold%0d: got valid=%b req=%b want valid=1 req=0", k, instr_valid, imem_req); end
            n_checks++; if (opcode !== 11'h458 || pc_out !== exp_addr) begin
                n_fails++; $display("FAIL zw_opcode%0d: got op=%h pc=%h want op=458 pc=%h", k, opcode, pc_out, exp_addr); end
            tick();
            exp_addr = exp_addr + 64'd4;
        end
    endtask

    // pc is 0xC on entry.
    task automatic test_wait_states();
        instr_ready = 1'b1;          // ignored while instr_valid=0
        take_branch = 1'b1;          // ignored outside an accept
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (imem_req !== 1'b1 || imem_addr !== 64'hC || instr_valid !== 1'b0) begin
                n_fails++; $display("FAIL ws_wait%0d: got req=%b addr=%h valid=%b want 1 c 0", k, imem_req, imem_addr, instr_valid); end
            tick();
        end
        take_branch = 1'b0;
        do_fetch(W_ADD);
        n_checks++; if (instr_valid !== 1'b1 || pc_out !== 64'hC) begin
            n_fails++; $display("FAIL ws_valid: got valid=%b pc=%h want 1 c", instr_valid, pc_out); end
        tick();
        n_checks++; if (imem_addr !== 64'h10) begin n_fails++; $display("FAIL ws_next: got %h want 10", imem_addr); end
    endtask

    // pc is 0x10 on entry.
    task automatic test_branches();
        instr_ready = 1'b1;
        do_fetch(W_B_M1);
        take_branch = 1'b1;
        tick();
        take_branch = 1'b0;
        n_checks++; if (imem_addr !== 64'hC || imem_req !== 1'b1) begin
            n_fails++; $display("FAIL b_neg: got addr=%h req=%b want c 1", imem_addr, imem_req); end
        do_fetch(W_B_3D);
        take_branch = 1'b1;
        tick();
        take_branch = 1'b0;
        n_checks++; if (imem_addr !== 64'h100) begin n_fails++; $display("FAIL b_pos: got %h want 100", imem_addr); end
        do_fetch(W_CBZ);
        n_checks++; if (instr !== W_CBZ || pc_out !== 64'h100) begin
            n_fails++; $display("FAIL cbz_held: got instr=%h pc=%h want b4000040 100", instr, pc_out); end
        tick();
        n_checks++; if (imem_addr !== 64'h104) begin n_fails++; $display("FAIL cbz_not_taken: got %h want 104", imem_addr); end
        do_fetch(W_B_M1);
        take_branch = 1'b1;
        tick();
        n_checks++; if (imem_addr !== 64'h100) begin n_fails++; $display("FAIL b_back: got %h want 100", imem_addr); end
        take_branch = 1'b0;
        do_fetch(W_CBZ);
        take_branch = 1'b1;
        tick();
        take_branch = 1'b0;
        n_checks++; if (imem_addr !== 64'h108) begin n_fails++; $display("FAIL cbz_taken: got %h want 108", imem_addr); end
    endtask

    task automatic test_wrap();
        do_reset();
        instr_ready = 1'b1;
        do_fetch(W_B_M1);
        take_branch = 1'b1;
        tick();
        take_branch = 1'b0;
        n_checks++; if (imem_addr !== 64'hFFFFFFFFFFFFFFFC) begin
            n_fails++; $display("FAIL b_wrap: got %h want fffffffffffffffc", imem_addr); end
    endtask

    task automatic test_hold_stall();
        do_reset();
        do_fetch(W_ADD);
        for (int k = 0; k < 5; k++) begin
            n_checks++; if (instr_valid !== 1'b1 || instr !== W_ADD || pc_out !== 64'h0 || imem_req !== 1'b0) begin
                n_fails++; $display("FAIL stall%0d: got valid=%b instr=%h pc=%h req=%b want 1 8b020020 0 0",
                                    k, instr_valid, instr, pc_out, imem_req); end
            tick();
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        n_checks++; if (imem_addr !== 64'h4 || imem_req !== 1'b1) begin
            n_fails++; $display("FAIL stall_release: got addr=%h req=%b want 4 1", imem_addr, imem_req); end
        do_fetch(W_ADD);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        n_checks++; if (instr_valid !== 1'b0 || instr !== 32'h0 || imem_req !== 1'b0) begin
            n_fails++; $display("FAIL mid_reset: got valid=%b instr=%h req=%b want 0 0 0", instr_valid, instr, imem_req); end
        rst_n = 1'b1;
        #1;
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin
            n_fails++; $display("FAIL refetch: got req=%b addr=%h want 1 0", imem_req, imem_addr); end
    endtask

    task automatic test_zero_word();
        do_reset();
        instr_ready = 1'b0;
        do_fetch(32'h0);
`ifdef IFU_HALT_ON_ZERO_EN
        instr_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (halted !== 1'b1 || instr_valid !== 1'b0 || imem_req !== 1'b0) begin
                n_fails++; $display("FAIL halt%0d: got halted=%b valid=%b req=%b want 1 0 0", k, halted, instr_valid, imem_req); end
            tick();
        end
        do_reset();
        n_checks++; if (halted !== 1'b0 || imem_req !== 1'b1) begin
            n_fails++; $display("FAIL halt_exit: got halted=%b req=%b want 0 1", halted, imem_req); end
`else
        n_checks++; if (instr_valid !== 1'b1 || instr !== 32'h0 || halted !== 1'b0) begin
            n_fails++; $display("FAIL zero_word: got valid=%b instr=%h halted=%b want 1 0 0", instr_valid, instr, halted); end
        instr_ready = 1'b1;
        tick();
        n_checks++; if (imem_addr !== 64'h4 || halted !== 1'b0) begin
            n_fails++; $display("FAIL zero_next: got addr=%h halted=%b want 4 0", imem_addr, halted); end
`endif
    endtask

    initial begin
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        instr_ready = 1'b0;
        take_branch = 1'b0;
        rst_n       = 1'b0;
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_branches();
        test_wrap();
        test_hold_stall();
        test_zero_word();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
